// File: rtl/button_event_ctrl.sv
// button_event_ctrl: debounces NUM_BTNS raw buttons off one shared sample tick and
// serialises press/release/long/repeat events through a round-robin valid/ready port.
module button_event_ctrl #(
  parameter int NUM_BTNS       = 4,
  parameter int CLK_PERIOD_NS  = 10,
  parameter int SAMPLE_MS      = 1,
  parameter int TICK_MAX       = SAMPLE_MS * 1_000_000 / CLK_PERIOD_NS,
  parameter int STABLE_SAMPLES = 5,
  parameter int LONG_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 200
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [NUM_BTNS-1:0]         dirty_in,
  output logic [NUM_BTNS-1:0]         clean_out,
  output logic                        ev_valid_out,
  input  logic                        ev_ready_in,
  output logic [$clog2(NUM_BTNS)-1:0] ev_btn_out,
  output logic [1:0]                  ev_type_out,
  output logic                        overrun_out
);
  localparam int BTN_W    = $clog2(NUM_BTNS);
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int STAB_W   = $clog2(STABLE_SAMPLES + 1);
  localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;
  localparam logic [1:0] EV_REPEAT  = 2'd3;

  typedef enum logic [1:0] {ST_RELEASED, ST_PRESSED, ST_HELD} state_t;

  logic [NUM_BTNS-1:0] r_sync1, r_sync2, r_clean, w_clean_nxt;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic                w_tick;
  logic [STAB_W-1:0]   r_stab [NUM_BTNS];
  state_t              r_state [NUM_BTNS];
  logic [HOLD_W-1:0]   r_hold [NUM_BTNS];
  logic [NUM_BTNS-1:0] w_raise;
  logic [1:0]          w_raise_type [NUM_BTNS];
  logic [NUM_BTNS-1:0] r_pend_flag;
  logic [1:0]          r_pend_type [NUM_BTNS];
  logic [BTN_W-1:0]    r_last, r_btn, w_grant_idx;
  logic [1:0]          r_type;
  logic                r_valid, r_overrun, w_load, w_grant_ok;
  logic [NUM_BTNS-1:0] w_grant;

  function automatic logic [BTN_W-1:0] rr_idx(input logic [BTN_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return BTN_W'(sum % NUM_BTNS);
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_tick_cnt <= '0;
    end else begin
      r_sync1    <= dirty_in;
      r_sync2    <= r_sync1;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_W'(TICK_MAX - 1));

  // The channel FSMs look at the level debounce is about to commit, so an edge and
  // its event are produced on the same tick.
  always_comb begin
    for (int i = 0; i < NUM_BTNS; i++) begin
      w_clean_nxt[i] = r_clean[i];
      if (w_tick && (r_sync2[i] != r_clean[i]) &&
          (r_stab[i] == STAB_W'(STABLE_SAMPLES - 1)))
        w_clean_nxt[i] = ~r_clean[i];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_clean <= '0;
      for (int i = 0; i < NUM_BTNS; i++) r_stab[i] <= '0;
    end else if (w_tick) begin
      r_clean <= w_clean_nxt;
      for (int i = 0; i < NUM_BTNS; i++) begin
        if ((r_sync2[i] == r_clean[i]) || (w_clean_nxt[i] != r_clean[i]))
          r_stab[i] <= '0;
        else
          r_stab[i] <= r_stab[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BTNS; i++) begin
      w_raise[i]      = 1'b0;
      w_raise_type[i] = EV_PRESS;
      if (w_tick) begin
        case (r_state[i])
          ST_RELEASED: w_raise[i] = w_clean_nxt[i];
          ST_PRESSED, ST_HELD: begin
            if (!w_clean_nxt[i]) begin
              w_raise[i]      = 1'b1;
              w_raise_type[i] = EV_RELEASE;
            end else if (r_state[i] == ST_PRESSED &&
                         r_hold[i] == HOLD_W'(LONG_TICKS - 1)) begin
              w_raise[i]      = 1'b1;
              w_raise_type[i] = EV_LONG;
            end else if (r_state[i] == ST_HELD &&
                         r_hold[i] == HOLD_W'(REPEAT_TICKS - 1)) begin
              w_raise[i]      = 1'b1;
              w_raise_type[i] = EV_REPEAT;
            end
          end
          default: w_raise[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_BTNS; i++) begin
        r_state[i] <= ST_RELEASED;
        r_hold[i]  <= '0;
      end
    end else if (w_tick) begin
      for (int i = 0; i < NUM_BTNS; i++) begin
        case (r_state[i])
          ST_RELEASED: begin
            if (w_clean_nxt[i]) begin
              r_state[i] <= ST_PRESSED;
              r_hold[i]  <= '0;
            end
          end
          ST_PRESSED: begin
            if (!w_clean_nxt[i]) begin
              r_state[i] <= ST_RELEASED;
            end else if (r_hold[i] == HOLD_W'(LONG_TICKS - 1)) begin
              r_state[i] <= ST_HELD;
              r_hold[i]  <= '0;
            end else begin
              r_hold[i]  <= r_hold[i] + 1'b1;
            end
          end
          ST_HELD: begin
            if (!w_clean_nxt[i])
              r_state[i] <= ST_RELEASED;
            else if (r_hold[i] == HOLD_W'(REPEAT_TICKS - 1))
              r_hold[i]  <= '0;
            else
              r_hold[i]  <= r_hold[i] + 1'b1;
          end
          default: r_state[i] <= ST_RELEASED;
        endcase
      end
    end
  end

  // Walk from farthest to nearest so the nearest pending channel after r_last wins.
  always_comb begin
    w_grant_ok  = 1'b0;
    w_grant_idx = '0;
    for (int k = NUM_BTNS; k >= 1; k--) begin
      if (r_pend_flag[rr_idx(r_last, k)]) begin
        w_grant_ok  = 1'b1;
        w_grant_idx = rr_idx(r_last, k);
      end
    end
  end

  assign w_load = ~r_valid | ev_ready_in;

  always_comb begin
    w_grant = '0;
    if (w_load && w_grant_ok) w_grant[w_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pend_flag <= '0;
      for (int i = 0; i < NUM_BTNS; i++) r_pend_type[i] <= '0;
      r_overrun   <= 1'b0;
      r_valid     <= 1'b0;
      r_btn       <= '0;
      r_type      <= '0;
      r_last      <= BTN_W'(NUM_BTNS - 1);
    end else begin
      r_overrun <= |(w_raise & r_pend_flag & ~w_grant);
      for (int i = 0; i < NUM_BTNS; i++) begin
        if (w_raise[i]) begin
          r_pend_flag[i] <= 1'b1;
          r_pend_type[i] <= w_raise_type[i];
        end else if (w_grant[i]) begin
          r_pend_flag[i] <= 1'b0;
        end
      end
      if (w_load) begin
        r_valid <= w_grant_ok;
        if (w_grant_ok) begin
          r_btn  <= w_grant_idx;
          r_type <= r_pend_type[w_grant_idx];
          r_last <= w_grant_idx;
        end
      end
    end
  end

  assign clean_out    = r_clean;
  assign ev_valid_out = r_valid;
  assign ev_btn_out   = r_btn;
  assign ev_type_out  = r_type;
  assign overrun_out  = r_overrun;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed scenarios plus randomized button activity,
// every cycle compared against a tick-arithmetic reference model.
module tb_button_event_ctrl;
  localparam int N  = 4;
  localparam int BW = 2;
  localparam int TM = 4;
  localparam int ST = 3;
  localparam int LG = 8;
  localparam int RP = 3;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [N-1:0]  dirty_in = '0;
  logic          ev_ready_in = 1'b0;
  logic [N-1:0]  clean_out;
  logic          ev_valid_out;
  logic [BW-1:0] ev_btn_out;
  logic [1:0]    ev_type_out;
  logic          overrun_out;

  button_event_ctrl #(
    .NUM_BTNS(N), .CLK_PERIOD_NS(10), .SAMPLE_MS(1), .TICK_MAX(TM),
    .STABLE_SAMPLES(ST), .LONG_TICKS(LG), .REPEAT_TICKS(RP)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .dirty_in(dirty_in), .clean_out(clean_out),
    .ev_valid_out(ev_valid_out), .ev_ready_in(ev_ready_in), .ev_btn_out(ev_btn_out),
    .ev_type_out(ev_type_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  // reference model state
  logic [N-1:0]  m_s1, m_s2, m_clean, m_pf;
  logic [1:0]    m_pt [N];
  int            m_run [N];
  int            m_press_tick [N];
  int            m_cyc, m_ticks, m_last;
  logic          m_valid, m_ov;
  logic [BW-1:0] m_btn;
  logic [1:0]    m_type;

  int checks = 0;
  int errors = 0;
  int cyc_no, first_clean0, first_valid, ov_seen;
  logic [3:0] ev_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_clean = '0; m_pf = '0;
    for (int i = 0; i < N; i++) begin
      m_pt[i] = '0; m_run[i] = 0; m_press_tick[i] = 0;
    end
    m_cyc = 0; m_ticks = 0; m_last = N - 1;
    m_valid = 1'b0; m_ov = 1'b0; m_btn = '0; m_type = '0;
    cyc_no = 0; first_clean0 = -1; first_valid = -1;
  endtask

  // Advance the model by one clock using the inputs that were present before the edge.
  task automatic model_step();
    logic         tick, ov;
    logic [N-1:0] nc, raise, pf_old;
    logic [1:0]   rtype [N];
    int           g, el, c;
    tick = ((m_cyc % TM) == TM - 1);
    m_cyc++;
    nc = m_clean;
    raise = '0;
    for (int i = 0; i < N; i++) begin
      rtype[i] = 2'd0;
      if (tick) begin
        if (m_s2[i] != m_clean[i]) begin
          m_run[i]++;
          if (m_run[i] == ST) begin
            nc[i] = ~m_clean[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        if (!m_clean[i] && nc[i]) begin
          raise[i] = 1'b1; rtype[i] = 2'd0; m_press_tick[i] = m_ticks;
        end else if (m_clean[i] && !nc[i]) begin
          raise[i] = 1'b1; rtype[i] = 2'd1;
        end else if (m_clean[i]) begin
          el = m_ticks - m_press_tick[i];
          if (el == LG) begin
            raise[i] = 1'b1; rtype[i] = 2'd2;
          end else if (el > LG && ((el - LG) % RP) == 0) begin
            raise[i] = 1'b1; rtype[i] = 2'd3;
          end
        end
      end
    end
    if (tick) m_ticks++;
    pf_old = m_pf;
    g = -1;
    if (!m_valid || ev_ready_in) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (g < 0 && m_pf[c]) g = c;
      end
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_btn = g[BW-1:0]; m_type = m_pt[g]; m_last = g; m_pf[g] = 1'b0;
      end
    end
    ov = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (raise[i]) begin
        if (pf_old[i] && g != i) ov = 1'b1;
        m_pf[i] = 1'b1;
        m_pt[i] = rtype[i];
      end
    end
    m_ov = ov;
    m_s2 = m_s1;
    m_s1 = dirty_in;
    m_clean = nc;
  endtask

  task automatic cycle();
    logic       hs;
    logic [3:0] hv;
    hs = ev_valid_out && ev_ready_in;
    hv = {ev_btn_out, ev_type_out};
    @(posedge clk_in);
    if (hs) ev_log.push_back(hv);
    #1;
    model_step();
    cyc_no++;
    @(negedge clk_in);
    chk("clean", clean_out, m_clean);
    chk("valid", ev_valid_out, m_valid);
    chk("overrun", overrun_out, m_ov);
    if (m_valid) begin
      chk("btn", ev_btn_out, m_btn);
      chk("type", ev_type_out, m_type);
    end
    if (overrun_out) ov_seen++;
    if (first_clean0 < 0 && clean_out[0]) first_clean0 = cyc_no;
    if (first_valid < 0 && ev_valid_out) first_valid = cyc_no;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("rst_valid", ev_valid_out, 1'b0);
    chk("rst_clean", clean_out, '0);
    rst_in = 1'b0;
    model_reset();
  endtask

  // Handshaken events since the last call, packed one nibble {btn,type} per entry, oldest lowest.
  task automatic expect_log(input string tag, input int n, input logic [31:0] packed_list);
    chk({tag, "_count"}, ev_log.size(), n);
    for (int i = 0; i < n; i++)
      chk(tag, (i < ev_log.size()) ? {28'h0, ev_log[i]} : 32'hFF, {28'h0, packed_list[4*i +: 4]});
    ev_log.delete();
  endtask

  initial begin
    int rate, rdy_pct;
    model_reset();
    repeat (3) @(negedge clk_in);
    chk("reset_clean", clean_out, '0);
    chk("reset_valid", ev_valid_out, 1'b0);
    chk("reset_overrun", overrun_out, 1'b0);
    chk("reset_btn", ev_btn_out, '0);
    chk("reset_type", ev_type_out, '0);

    // button 0 held steady: debounced press, then released
    dirty_in = 4'b0001;
    ev_ready_in = 1'b1;
    rst_in = 1'b0;
    model_reset();
    run(24);
    chk("t1_clean_cycle", first_clean0, ST * TM);
    chk("t1_valid_cycle", first_valid, ST * TM + 1);
    dirty_in = 4'b0000;
    run(24);
    expect_log("t1_events", 2, 32'h0000_0010);

    // two-tick glitch on button 1 never gets through
    dirty_in = 4'b0010;
    run(2 * TM);
    dirty_in = 4'b0000;
    run(40);
    expect_log("t2_events", 0, 32'h0);
    chk("t2_clean", clean_out, 4'b0000);

    // button 2 held for 20 ticks: press, long, three repeats, release
    dirty_in = 4'b0100;
    run(20 * TM);
    dirty_in = 4'b0000;
    run(40);
    expect_log("t3_events", 6, 32'h009B_BBA8);

    // all buttons on the same tick: round-robin from channel 0, releases continue after 3
    do_reset();
    dirty_in = 4'b1111;
    run(20);
    dirty_in = 4'b0000;
    run(30);
    expect_log("t4_events", 8, 32'hD951_C840);

    // consumer stalled: btn 3 release overwrites its press
    do_reset();
    ev_ready_in = 1'b0;
    ov_seen = 0;
    dirty_in = 4'b0001;
    run(20);
    dirty_in = 4'b1000;
    run(24);
    dirty_in = 4'b0000;
    run(24);
    chk("t5_overrun_pulses", ov_seen, 1);
    chk("t5_hold_valid", ev_valid_out, 1'b1);
    chk("t5_hold_btn", ev_btn_out, 2'd0);
    chk("t5_hold_type", ev_type_out, 2'd0);
    ev_ready_in = 1'b1;
    run(10);
    expect_log("t5_events", 3, 32'h0000_01D0);

    // asynchronous reset while button 1 is in the held state
    dirty_in = 4'b0010;
    run(60);
    ev_log.delete();
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    #1;
    chk("t6_clean", clean_out, '0);
    chk("t6_valid", ev_valid_out, 1'b0);
    chk("t6_overrun", overrun_out, 1'b0);
    chk("t6_btn", ev_btn_out, '0);
    chk("t6_type", ev_type_out, '0);
    @(negedge clk_in);
    dirty_in = 4'b0000;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    ev_log.delete();
    run(30);
    expect_log("t6_quiet", 0, 32'h0);
    chk("t6_quiet_clean", clean_out, '0);
    dirty_in = 4'b0010;
    run(20);
    expect_log("t6_repress", 1, 32'h0000_0004);

    // randomized activity with mixed glitch rates and consumer stalls
    do_reset();
    for (int seg = 0; seg < 10; seg++) begin
      rate    = (seg % 2 == 1) ? 150 : 12;
      rdy_pct = (seg % 3 == 0) ? 10 : 80;
      for (int c = 0; c < 200; c++) begin
        for (int b = 0; b < N; b++)
          if ($urandom_range(rate - 1, 0) == 0) dirty_in[b] = ~dirty_in[b];
        ev_ready_in = ($urandom_range(99, 0) < rdy_pct);
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
